// File: rtl/glip_arb_pkg.sv
// glip_arb_pkg: shared types and constants for the GLIP stream arbiter.
//   arb_state_e      FSM state encoding (IDLE / HDR / DATA)
//   HDR_MARKER       marker nibble in the top bits of every header word
//   HDR_*            header field widths; the marker sits at [WIDTH-1 -: 4],
//                    the granted channel at [WIDTH-5 -: 4], the burst length
//                    at [7:0], and any bits in between are zero.
package glip_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam logic [3:0] HDR_MARKER   = 4'hA;
  localparam int         HDR_MARKER_W = 4;
  localparam int         HDR_GRANT_W  = 4;
  localparam int         HDR_LEN_W    = 8;
  localparam int         GRANT_W      = 4;
  localparam int         BEAT_W       = 8;

endpackage

// File: rtl/glip_stream_arbiter_if.sv
// glip_stream_arbiter_if: bundle of the NCH requester channels and the merged
// output stream.
//   in_data   NCH*WIDTH  channel c word at [c*WIDTH +: WIDTH]
//   in_valid  NCH        channel word valid
//   in_ready  NCH        channel word accepted
//   out_data  WIDTH      merged stream word
//   out_valid 1          merged stream valid
//   out_ready 1          merged stream ready
// Handshake: a word moves on a rising clk edge where valid and ready are both
// high; a producer must not use ready to decide valid, and an offered word
// (valid high) is held until it is taken.
// Modports: slave = the arbiter, master = the surrounding channels + sink.
interface glip_stream_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/glip_rr_picker.sv
// glip_rr_picker: combinational round-robin pick.
//   i_req    NCH  request vector
//   i_ptr    4    channel with highest priority this round
//   o_found  1    at least one request is set
//   o_idx    4    first requesting channel at or after i_ptr, wrapping
module glip_rr_picker #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] i_req,
  input  logic [3:0]     i_ptr,
  output logic           o_found,
  output logic [3:0]     o_idx
);

  // Each requester gets a distance from the pointer (mod NCH); the smallest
  // distance wins, which is the same as scanning forward from the pointer.
  always_comb begin
    int best_off;
    int off;
    o_found  = 1'b0;
    o_idx    = '0;
    best_off = NCH;
    off      = 0;
    for (int c = 0; c < NCH; c++) begin
      off = c - int'(i_ptr);
      if (off < 0) off = off + NCH;
      if (i_req[c] && (off < best_off)) begin
        best_off = off;
        o_found  = 1'b1;
        o_idx    = 4'(c);
      end
    end
  end

endmodule

// File: rtl/glip_stream_arbiter.sv
// glip_stream_arbiter: merges NCH word channels into one stream of fixed-length
// bursts. Each burst is one header word followed by MAX_BURST words from the
// granted channel. Channels are picked round-robin among enabled requesters.
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   cfg_enable  NCH  per-channel arbitration enable
//   bus         glip_stream_arbiter_if.slave, channel inputs + merged output
//   busy        1    high in HDR or DATA
//   grant       4    current or last granted channel
//   dbg_state   FSM state for observation
module glip_stream_arbiter
  import glip_arb_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NCH       = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        cfg_enable,
  glip_stream_arbiter_if.slave  bus,
  output logic                  busy,
  output logic [GRANT_W-1:0]    grant,
  output arb_state_e            dbg_state
);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [GRANT_W-1:0]  r_grant;
  logic [GRANT_W-1:0]  r_rr_ptr;
  logic [BEAT_W-1:0]   r_beat;
  logic [WIDTH-1:0]    r_hdr;

  logic [NCH-1:0]      w_req;
  logic                w_found;
  logic [GRANT_W-1:0]  w_pick;
  logic [WIDTH-1:0]    w_hdr;
  logic [WIDTH-1:0]    w_sel_data;
  logic                w_sel_valid;
  logic                w_data_hs;
  logic                w_last_beat;

  assign w_req = bus.in_valid & cfg_enable;

  glip_rr_picker #(.NCH(NCH)) u_picker (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  always_comb begin
    w_hdr = '0;
    w_hdr[WIDTH-1 -: HDR_MARKER_W]              = HDR_MARKER;
    w_hdr[WIDTH-HDR_MARKER_W-1 -: HDR_GRANT_W]  = w_pick;
    w_hdr[HDR_LEN_W-1:0]                        = HDR_LEN_W'(MAX_BURST);
  end

  // Mux of the granted channel, used for DATA-phase pass-through.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (r_grant == GRANT_W'(c)) begin
        w_sel_data  = bus.in_data[c*WIDTH +: WIDTH];
        w_sel_valid = bus.in_valid[c];
      end
    end
  end

  assign w_data_hs   = (r_state == ST_DATA) && w_sel_valid && bus.out_ready;
  assign w_last_beat = (r_beat == BEAT_W'(MAX_BURST - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic. A burst, once granted, always runs to MAX_BURST words;
  // a channel that stops offering data simply stalls DATA.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_found)                  w_state_nxt = ST_HDR;
      ST_HDR:  if (bus.out_ready)            w_state_nxt = ST_DATA;
      ST_DATA: if (w_data_hs && w_last_beat) w_state_nxt = ST_IDLE;
      default:                               w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant, header, beat counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_beat   <= '0;
      r_hdr    <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_found) begin
        r_grant <= w_pick;
        r_hdr   <= w_hdr;
      end
      if ((r_state == ST_HDR) && bus.out_ready) r_beat <= '0;
      if (w_data_hs) begin
        r_beat <= r_beat + 1'b1;
        if (w_last_beat)
          r_rr_ptr <= (r_grant == GRANT_W'(NCH - 1)) ? '0 : r_grant + 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.in_ready  = '0;
    busy          = 1'b0;
    case (r_state)
      ST_HDR: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_hdr;
        busy          = 1'b1;
      end
      ST_DATA: begin
        bus.out_valid = w_sel_valid;
        bus.out_data  = w_sel_data;
        busy          = 1'b1;
        for (int c = 0; c < NCH; c++)
          bus.in_ready[c] = (r_grant == GRANT_W'(c)) && bus.out_ready;
      end
      default: ;
    endcase
  end

  assign grant     = r_grant;
  assign dbg_state = r_state;

endmodule

// File: doc/glip_stream_arbiter.md
GLIP_STREAM_ARBITER -- requirements
Module: glip_stream_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: data word width (16 or 32) for both the input channels and the output stream.
REQ-002 Parameter NCH, default 4: number of requester channels, legal range 2..16.
REQ-003 Parameter MAX_BURST, default 16: data words per burst, legal range 1..255.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 cfg_enable  input  NCH: per-channel arbitration enable.
REQ-007 in_data  input  NCH*WIDTH: channel c data occupies bits [c*WIDTH +: WIDTH].
REQ-008 in_valid  input  NCH: per-channel word valid.
REQ-009 in_ready  output  NCH: per-channel word accepted.
REQ-010 out_data  output  WIDTH: merged stream to the GLIP Logic->Host FIFO (fifo_in_data).
REQ-011 out_valid  output  1: merged stream valid.
REQ-012 out_ready  input  1: merged stream ready (fifo_in_ready).
REQ-013 busy  output  1: high in HDR or DATA.
REQ-014 grant  output  4: index of the current or last granted channel.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, HDR and DATA.
REQ-016 In IDLE, when any channel has in_valid&cfg_enable, the block SHALL select the first such channel at or after rr_ptr (wrapping NCH-1 to 0), register grant, load the header and enter HDR on the next cycle.
REQ-017 In IDLE with no eligible channel, the block SHALL stay in IDLE with out_valid=0.
REQ-018 Header word fields: [WIDTH-1:WIDTH-4]=4'hA; [WIDTH-5:WIDTH-8]=grant; [7:0]=MAX_BURST; remaining bits (WIDTH=32) =0.
REQ-019 In HDR, out_valid=1 and out_data=header, held stable until out_ready; on handshake go to DATA with beat counter=0.
REQ-020 In DATA, routing SHALL be combinational: out_data=in_data[grant], out_valid=in_valid[grant], in_ready[grant]=out_ready; all other in_ready bits =0.
REQ-021 The beat counter SHALL increment on each DATA handshake (out_valid&out_ready).
REQ-022 On the handshake with counter==MAX_BURST-1, the block SHALL go to IDLE and set rr_ptr=(grant+1) mod NCH.
REQ-023 The committed burst length is MAX_BURST: if in_valid[grant] drops mid-burst, the block SHALL wait in DATA with out_valid=0 and SHALL NOT abort.
REQ-024 cfg_enable changes SHALL affect only the next IDLE selection; a burst in progress always completes.
REQ-025 In IDLE and HDR, all in_ready bits SHALL be 0.
REQ-026 Back-to-back operation: the IDLE->HDR->DATA path costs exactly 1 idle cycle (IDLE) plus 1 header beat per burst when out_ready=1.
REQ-027 Throughput SHALL never exceed one word per cycle; no word is duplicated, dropped or reordered within a channel.

Reset
REQ-028 While rst_n=0: state=IDLE, rr_ptr=0, grant=0, beat counter=0, out_valid=0, out_data=0, in_ready=0, busy=0.
REQ-029 Assertion of rst_n mid-burst SHALL abandon the burst immediately; no partial-burst recovery is required.
REQ-030 After rst_n deassertion, the first selection SHALL occur on the first rising clk edge.

Structure
REQ-031 Package glip_arb_pkg SHALL hold the state enum, HDR_MARKER=4'hA and the header field positions.
REQ-032 Round-robin selection SHALL be a sub-module glip_rr_picker (inputs: request vector, pointer; outputs: found, index; purely combinational).
REQ-033 The beat counter SHALL be 8 bits wide; no other storage beyond state, grant, rr_ptr and the header register.

Verification
REQ-034 NCH=4, MAX_BURST=4, only ch2 valid with data 0x1000..0x1003 -> out: 0xA204,0x1000..0x1003; grant=2; then IDLE.
REQ-035 All four channels continuously valid, out_ready=1 -> header channel order 0,1,2,3,0; exactly 1 IDLE cycle between bursts.
REQ-036 ch1 drops in_valid for 3 cycles after beat 2 -> out_valid=0 for 3 cycles, burst resumes and completes with 4 data beats, no extra header.
REQ-037 out_ready toggled randomly (50%) -> header held stable while stalled; in_ready[grant] equals out_ready in DATA; scoreboard matches per-channel order.
REQ-038 cfg_enable=4'b1011 with all valid -> ch2 never granted; clearing bit 0 during ch0's burst -> burst completes, ch0 skipped afterward.
REQ-039 rst_n pulsed low at DATA beat 1 -> out_valid and in_ready fall asynchronously to 0; the next grant after release is the lowest eligible channel, since rr_ptr=0.
